// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one W-bit adder among N valid/ready requesters.
// Optional ADD_ARB_SAT_EN: unsigned saturation of rsp_y (rsp_co stays raw carry).
module add_arbiter #(
  parameter  int N   = 4,
  parameter  int W   = 8,
  localparam int IDW = $clog2(N)
) (
  input  logic             c,
  input  logic             r,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  output logic [N-1:0]     req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [W-1:0]     rsp_y,
  output logic             rsp_co
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [W-1:0]     r_y;
  logic             r_co;

  logic             w_found;
  logic [IDW-1:0]   w_gnt;
  logic             w_can_accept;
  logic             w_xfer;
  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;
  logic [W:0]       w_sum;
  logic [W-1:0]     w_y;

  // Search ptr, ptr+1, ... wrapping at N-1; first valid requester wins.
  always_comb begin
    int unsigned    v_idx;
    logic [IDW-1:0] v_sel;
    w_found = 1'b0;
    w_gnt   = '0;
    v_idx   = 0;
    v_sel   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      v_idx = 32'(r_ptr) + k;
      if (v_idx >= N) v_idx = v_idx - N;
      v_sel = IDW'(v_idx);
      if (!w_found && req_valid[v_sel]) begin
        w_found = 1'b1;
        w_gnt   = v_sel;
      end
    end
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_gnt == IDW'(i)) begin
        w_a = req_a[i*W +: W];
        w_b = req_b[i*W +: W];
      end
    end
  end

  assign w_can_accept = !r && ((r_state == IDLE) || rsp_ready);
  assign w_xfer       = w_found && w_can_accept;
  assign w_sum        = {1'b0, w_a} + {1'b0, w_b};

`ifdef ADD_ARB_SAT_EN
  assign w_y = w_sum[W] ? '1 : w_sum[W-1:0];
`else
  assign w_y = w_sum[W-1:0];
`endif

  always_comb begin
    req_ready = '0;
    if (w_xfer) req_ready[w_gnt] = 1'b1;
  end

  // State register
  always_ff @(posedge c) begin
    if (r) r_state <= IDLE;
    else   r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer)
      w_state_nxt = HOLD;
    else if ((r_state == HOLD) && rsp_ready)
      w_state_nxt = IDLE;
  end

  // Output logic
  always_comb begin
    rsp_valid = (r_state == HOLD);
    rsp_id    = r_id;
    rsp_y     = r_y;
    rsp_co    = r_co;
  end

  always_ff @(posedge c) begin
    if (r) begin
      r_ptr <= '0;
      r_id  <= '0;
      r_y   <= '0;
      r_co  <= 1'b0;
    end else if (w_xfer) begin
      r_ptr <= (w_gnt == IDW'(N-1)) ? '0 : w_gnt + IDW'(1);
      r_id  <= w_gnt;
      r_y   <= w_y;
      r_co  <= w_sum[W];
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
// Directed self-checking bench for add_arbiter (N=4, W=8); honours ADD_ARB_SAT_EN.
module tb_add_arbiter;

  logic        c = 1'b0;
  logic        r;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_y;
  logic        rsp_co;

  int checks = 0;
  int errors = 0;

`ifdef ADD_ARB_SAT_EN
  localparam logic [7:0] T3_Y = 8'hFF;
`else
  localparam logic [7:0] T3_Y = 8'h01;
`endif

  add_arbiter #(.N(4), .W(8)) dut (
    .c(c), .r(r), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_co(rsp_co)
  );

  always #5 c = ~c;

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    r = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1; req_a = '0; req_b = '0;
    tick(); tick();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b exp %b", req_ready, 4'b0000); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_y !== 8'h00) begin errors++; $display("FAIL rst_y got %h exp 00", rsp_y); end
    checks++; if (rsp_co !== 1'b0) begin errors++; $display("FAIL rst_co got %b exp 0", rsp_co); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL rst_id got %0d exp 0", rsp_id); end
    req_valid = 4'b0000; r = 1'b0;
    tick();
  endtask

  // T1: single add, ptr 0 -> 1
  task automatic test_single();
    req_valid = 4'b0001; req_a = 32'h0000_0012; req_b = 32'h0000_0034; rsp_ready = 1'b1;
    settle();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL t1_ready got %b exp 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got %b exp 1", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL t1_id got %0d exp 0", rsp_id); end
    checks++; if (rsp_y !== 8'h46) begin errors++; $display("FAIL t1_y got %h exp 46", rsp_y); end
    checks++; if (rsp_co !== 1'b0) begin errors++; $display("FAIL t1_co got %b exp 0", rsp_co); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL t1_drop got %b exp 0", rsp_valid); end
    checks++; if (rsp_y !== 8'h46) begin errors++; $display("FAIL t1_keep_y got %h exp 46", rsp_y); end
  endtask

  // T2: all requesting from ptr 0 -> grants 0,1,2,3,0; ends with ptr 1
  task automatic test_round_robin();
    logic [7:0] exp_y [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [3:0] exp_rdy;
    r = 1'b1; tick(); r = 1'b0;
    req_a = 32'h4030_2010; req_b = 32'h0403_0201; req_valid = 4'b1111; rsp_ready = 1'b1;
    settle();
    for (int k = 0; k < 5; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL t2_ready[%0d] got %b exp %b", k, req_ready, exp_rdy); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_y !== exp_y[k % 4])
        begin errors++; $display("FAIL t2_rsp[%0d] got v%b id%0d y%h exp v1 id%0d y%h", k, rsp_valid, rsp_id, rsp_y, k % 4, exp_y[k % 4]); end
    end
    req_valid = 4'b0000;
    tick();
  endtask

  // T3: overflow via requester 1 (ptr 1 -> 2)
  task automatic test_overflow();
    req_a = 32'h0000_FF00; req_b = 32'h0000_0200; req_valid = 4'b0010; rsp_ready = 1'b1;
    tick();
    req_valid = 4'b0000;
    checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL t3_id got %0d exp 1", rsp_id); end
    checks++; if (rsp_y !== T3_Y) begin errors++; $display("FAIL t3_y got %h exp %h", rsp_y, T3_Y); end
    checks++; if (rsp_co !== 1'b1) begin errors++; $display("FAIL t3_co got %b exp 1", rsp_co); end
    tick();
  endtask

  // T4: backpressure in HOLD (ptr 2 -> 0 after req 3 -> 2 after req 1)
  task automatic test_backpressure();
    req_a = 32'h0500_1000; req_b = 32'h0600_2000; req_valid = 4'b1000; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; req_valid = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL t4_ready[%0d] got %b exp 0000", k, req_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_y !== 8'h0B || rsp_co !== 1'b0)
        begin errors++; $display("FAIL t4_hold[%0d] got v%b id%0d y%h co%b exp v1 id3 y0b co0", k, rsp_valid, rsp_id, rsp_y, rsp_co); end
      tick();
    end
    rsp_ready = 1'b1;
    settle();
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL t4_release got %b exp 0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_y !== 8'h30)
      begin errors++; $display("FAIL t4_new got v%b id%0d y%h exp v1 id1 y30", rsp_valid, rsp_id, rsp_y); end
    tick();
  endtask

  // T5: reset while HOLD clears result and pointer
  task automatic test_reset_mid();
    req_a = 32'h0000_0001; req_b = 32'h0000_0001; req_valid = 4'b0001; rsp_ready = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_y !== 8'h02) begin errors++; $display("FAIL t5_pre got v%b y%h exp v1 y02", rsp_valid, rsp_y); end
    r = 1'b1; req_valid = 4'b1001; rsp_ready = 1'b1;
    settle();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL t5_rst_ready got %b exp 0000", req_ready); end
    tick();
    r = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || rsp_y !== 8'h00 || rsp_id !== 2'd0 || rsp_co !== 1'b0)
      begin errors++; $display("FAIL t5_clear got v%b y%h id%0d co%b exp v0 y00 id0 co0", rsp_valid, rsp_y, rsp_id, rsp_co); end
    req_a = 32'h0900_0007; req_b = 32'h0100_0008;
    settle();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL t5_first got %b exp 0001", req_ready); end
    tick();
    checks++; if (rsp_id !== 2'd0 || rsp_y !== 8'h0F) begin errors++; $display("FAIL t5_r0 got id%0d y%h exp id0 y0f", rsp_id, rsp_y); end
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL t5_second got %b exp 1000", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if (rsp_id !== 2'd3 || rsp_y !== 8'h0A) begin errors++; $display("FAIL t5_r3 got id%0d y%h exp id3 y0a", rsp_id, rsp_y); end
    tick();
  endtask

  // T6: withdrawal under backpressure leaves ptr at 2
  task automatic test_withdraw();
    req_a = 32'h0000_2200; req_b = 32'h0000_1100; req_valid = 4'b0010; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; req_valid = 4'b0100;
    settle();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL t6_nogrant got %b exp 0000", req_ready); end
    tick();
    req_valid = 4'b0000;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_y !== 8'h33)
      begin errors++; $display("FAIL t6_hold got v%b id%0d y%h exp v1 id1 y33", rsp_valid, rsp_id, rsp_y); end
    req_a = 32'h2000_0003; req_b = 32'h0200_0004; req_valid = 4'b1001; rsp_ready = 1'b1;
    settle();
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL t6_next got %b exp 1000", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_y !== 8'h22)
      begin errors++; $display("FAIL t6_rsp got v%b id%0d y%h exp v1 id3 y22", rsp_valid, rsp_id, rsp_y); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_withdraw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
